// File: rtl/piece_sched.sv
// piece_sched: sequencing controller for the active-piece write buffer and
// the collision checker. Arbitrates gravity against keyboard actions and runs
// one req/ack collision check at a time, then commits, locks or ends the game.
// Optional build macro: HARD_DROP_EN (keycode 0x2C drops the piece until it lands).
module piece_sched #(
  parameter int DROP_TICKS = 50,
  parameter int KEY_REPEAT = 8
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  input  logic       chk_ok,
  input  logic       chk_ack,
  input  logic       clear_done,
  output logic [2:0] state,
  output logic       chk_req,
  output logic [2:0] chk_op,
  output logic       commit,
  output logic       lock,
  output logic       swap_used,
  output logic       game_over
);

  localparam int GW = $clog2(DROP_TICKS + 1);
  localparam int RW = $clog2(KEY_REPEAT + 1);

  typedef enum logic [2:0] {
    ST_SPAWN = 3'b000, ST_IDLE  = 3'b001, ST_CHECK = 3'b010, ST_APPLY = 3'b011,
    ST_LOCK  = 3'b100, ST_CLEAR = 3'b101, ST_OVER  = 3'b110
  } state_e;

  localparam logic [2:0] OP_SPAWN = 3'd0;
  localparam logic [2:0] OP_LEFT  = 3'd1;
  localparam logic [2:0] OP_RIGHT = 3'd2;
  localparam logic [2:0] OP_DOWN  = 3'd3;
  localparam logic [2:0] OP_ROT   = 3'd4;
  localparam logic [2:0] OP_SWAP  = 3'd5;
  localparam logic [2:0] OP_HARD  = 3'd6;  // internal only, issued as DOWN checks

  // Map a keycode to {valid, op}; unknown codes are invalid.
  function automatic logic [3:0] key_decode(input logic [7:0] code);
    case (code)
      8'h04:   return {1'b1, OP_LEFT};
      8'h07:   return {1'b1, OP_RIGHT};
      8'h16:   return {1'b1, OP_DOWN};
      8'h1A:   return {1'b1, OP_ROT};
      8'h06:   return {1'b1, OP_SWAP};
`ifdef HARD_DROP_EN
      8'h2C:   return {1'b1, OP_HARD};
`endif
      default: return {1'b0, OP_SPAWN};
    endcase
  endfunction

  // Only lateral moves and soft drop auto-repeat while held.
  function automatic logic key_repeats(input logic [2:0] op);
    return (op == OP_LEFT) || (op == OP_RIGHT) || (op == OP_DOWN);
  endfunction

  state_e         state_q, state_d;
  logic [2:0]     op_q, op_d, pend_op_q, pend_op_d;
  logic           chk_req_q, commit_q, lock_q, swap_used_q, swap_used_d, game_over_q;
  logic           hard_q, hard_d, grav_pend_q, grav_pend_d, pend_q, pend_d;
  logic [GW-1:0]  grav_cnt_q, grav_cnt_d;
  logic [RW-1:0]  rep_cnt_q, rep_cnt_d;
  logic [7:0]     key_q;
  logic [3:0]     dec_s;
  logic           press_s, held_s, rep_hit_s, wrap_s, grav_clr_s, pend_clr_s;

  assign dec_s     = key_decode(keycode);
  assign press_s   = (keycode != key_q) && (keycode != 8'h00) && dec_s[3];
  assign held_s    = (keycode == key_q) && dec_s[3] && key_repeats(dec_s[2:0]);
  assign rep_hit_s = held_s && frame_tick && (rep_cnt_q == RW'(KEY_REPEAT - 1));

  // Main FSM: next state, check opcode and swap bookkeeping.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    swap_used_d = swap_used_q;
    hard_d      = hard_q;
    grav_clr_s  = 1'b0;
    pend_clr_s  = 1'b0;
    case (state_q)
      ST_SPAWN: begin
        state_d = ST_CHECK;
        op_d    = OP_SPAWN;
      end
      ST_IDLE: begin
        if (grav_pend_q) begin
          op_d       = OP_DOWN;
          grav_clr_s = 1'b1;
          state_d    = ST_CHECK;
        end else if (pend_q) begin
          pend_clr_s = 1'b1;
          if ((pend_op_q == OP_SWAP) && swap_used_q) begin
            state_d = ST_IDLE;
          end else if (pend_op_q == OP_HARD) begin
            op_d    = OP_DOWN;
            hard_d  = 1'b1;
            state_d = ST_CHECK;
          end else begin
            op_d    = pend_op_q;
            state_d = ST_CHECK;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (!chk_ack) begin
          state_d = ST_CHECK;
        end else if (chk_ok) begin
          state_d = ST_APPLY;
        end else begin
          case (op_q)
            OP_SPAWN: state_d = ST_OVER;
            OP_DOWN: begin
              state_d = ST_LOCK;
              hard_d  = 1'b0;
`ifdef HARD_DROP_EN
              grav_clr_s = 1'b1;
`endif
            end
            default:  state_d = ST_IDLE;
          endcase
        end
      end
      ST_APPLY: begin
        if (op_q == OP_SWAP) begin
          swap_used_d = 1'b1;
          state_d     = ST_SPAWN;
        end else if (hard_q) begin
          state_d = ST_CHECK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCK: begin
        swap_used_d = 1'b0;
        state_d     = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (clear_done) state_d = ST_SPAWN;
        else            state_d = ST_CLEAR;
      end
      ST_OVER:  state_d = ST_OVER;
      default:  state_d = ST_SPAWN;
    endcase
  end

  // Gravity counter, key auto-repeat and the one-deep pending event latch.
  always_comb begin
    grav_cnt_d  = grav_cnt_q;
    grav_pend_d = grav_pend_q;
    rep_cnt_d   = rep_cnt_q;
    pend_d      = pend_q;
    pend_op_d   = pend_op_q;
    wrap_s      = 1'b0;
    if ((state_q != ST_OVER) && frame_tick) begin
      if (grav_cnt_q == GW'(DROP_TICKS - 1)) begin
        grav_cnt_d = '0;
        wrap_s     = 1'b1;
      end else begin
        grav_cnt_d = grav_cnt_q + GW'(1);
      end
    end else begin
      grav_cnt_d = grav_cnt_q;
    end
    if (grav_clr_s) grav_pend_d = 1'b0;
    else            grav_pend_d = grav_pend_q;
    if (wrap_s) grav_pend_d = 1'b1;
    else        grav_pend_d = grav_pend_d;
    // A committed DOWN of either source restarts the gravity period.
    if ((state_q == ST_APPLY) && (op_q == OP_DOWN)) begin
      grav_cnt_d  = '0;
      grav_pend_d = 1'b0;
    end else begin
      grav_cnt_d  = grav_cnt_d;
    end
    if (state_q == ST_OVER) begin
      rep_cnt_d = rep_cnt_q;
    end else if (press_s) begin
      rep_cnt_d = '0;
    end else if (held_s && frame_tick) begin
      if (rep_hit_s) rep_cnt_d = '0;
      else           rep_cnt_d = rep_cnt_q + RW'(1);
    end else begin
      rep_cnt_d = rep_cnt_q;
    end
    if (pend_clr_s) pend_d = 1'b0;
    else            pend_d = pend_q;
    // A newer event overwrites one not yet serviced.
    if ((state_q != ST_OVER) && (press_s || rep_hit_s)) begin
      pend_d    = 1'b1;
      pend_op_d = dec_s[2:0];
    end else begin
      pend_op_d = pend_op_q;
    end
  end

  // State and registered outputs, decoded from the next state.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_SPAWN;
      op_q        <= OP_SPAWN;
      chk_req_q   <= 1'b0;
      commit_q    <= 1'b0;
      lock_q      <= 1'b0;
      swap_used_q <= 1'b0;
      game_over_q <= 1'b0;
      hard_q      <= 1'b0;
      grav_cnt_q  <= '0;
      grav_pend_q <= 1'b0;
      rep_cnt_q   <= '0;
      pend_q      <= 1'b0;
      pend_op_q   <= OP_SPAWN;
      key_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      chk_req_q   <= (state_d == ST_CHECK);
      commit_q    <= (state_d == ST_APPLY);
      lock_q      <= (state_d == ST_LOCK);
      swap_used_q <= swap_used_d;
      game_over_q <= game_over_q || (state_d == ST_OVER);
      hard_q      <= hard_d;
      grav_cnt_q  <= grav_cnt_d;
      grav_pend_q <= grav_pend_d;
      rep_cnt_q   <= rep_cnt_d;
      pend_q      <= pend_d;
      pend_op_q   <= pend_op_d;
      key_q       <= keycode;
    end
  end

  assign state     = state_q;
  assign chk_req   = chk_req_q;
  assign chk_op    = op_q;
  assign commit    = commit_q;
  assign lock      = lock_q;
  assign swap_used = swap_used_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_piece_sched.sv
// Directed bench for piece_sched with DROP_TICKS=4, KEY_REPEAT=8.
module tb_piece_sched;
  logic       Clk = 1'b0;
  logic       Reset_n, frame_tick, chk_ok, chk_ack, clear_done;
  logic [7:0] keycode;
  logic [2:0] state, chk_op;
  logic       chk_req, commit, lock, swap_used, game_over;

  int vectors = 0;
  int miscompares = 0;
  int ok_left = 0;
  int n_chk[8];
  int n_commit, n_lock, n_spawn;

  piece_sched #(.DROP_TICKS(4), .KEY_REPEAT(8)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .keycode(keycode),
    .chk_ok(chk_ok), .chk_ack(chk_ack), .clear_done(clear_done),
    .state(state), .chk_req(chk_req), .chk_op(chk_op), .commit(commit),
    .lock(lock), .swap_used(swap_used), .game_over(game_over)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_counts();
    for (int i = 0; i < 8; i++) n_chk[i] = 0;
    n_commit = 0;
    n_lock   = 0;
    n_spawn  = 0;
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
  endtask

  task automatic answer(input logic ok);
    chk_ok  = ok;
    chk_ack = 1'b1;
    tick();
    chk_ack = 1'b0;
    chk_ok  = 1'b0;
  endtask

  // ncyc cycles with an automatic checker responder; optional frame on cycle 0.
  task automatic drive(input int ncyc, input logic ftick);
    for (int c = 0; c < ncyc; c++) begin
      frame_tick = ftick && (c == 0);
      if (chk_req === 1'b1) begin
        chk_ack = 1'b1;
        chk_ok  = (ok_left > 0);
        if (ok_left > 0) ok_left--;
        n_chk[chk_op]++;
      end else begin
        chk_ack = 1'b0;
        chk_ok  = 1'b0;
      end
      tick();
      if (commit === 1'b1) n_commit++;
      if (lock === 1'b1) n_lock++;
      if (state === 3'b000) n_spawn++;
    end
    frame_tick = 1'b0;
    chk_ack    = 1'b0;
    chk_ok     = 1'b0;
  endtask

  task automatic run_frames(input int n);
    for (int f = 0; f < n; f++) drive(12, 1'b1);
  endtask

  initial begin
    Reset_n = 1'b0; frame_tick = 1'b0; keycode = 8'h00;
    chk_ok = 1'b0; chk_ack = 1'b0; clear_done = 1'b0;
    clr_counts();
    tick(); tick();
    check("rst_state", 32'(state), 32'h0);
    check("rst_chk_req", 32'(chk_req), 32'h0);
    check("rst_chk_op", 32'(chk_op), 32'h0);
    check("rst_commit", 32'(commit), 32'h0);
    check("rst_lock", 32'(lock), 32'h0);
    check("rst_swap_used", 32'(swap_used), 32'h0);
    check("rst_game_over", 32'(game_over), 32'h0);

    // First spawn: SPAWN -> CHECK -> APPLY -> IDLE
    Reset_n = 1'b1;
    tick();
    check("spawn_state_check", 32'(state), 32'h2);
    check("spawn_req", 32'(chk_req), 32'h1);
    check("spawn_op", 32'(chk_op), 32'h0);
    answer(1'b1);
    check("spawn_state_apply", 32'(state), 32'h3);
    check("spawn_commit", 32'(commit), 32'h1);
    check("spawn_req_drop", 32'(chk_req), 32'h0);
    tick();
    check("spawn_state_idle", 32'(state), 32'h1);
    check("spawn_commit_end", 32'(commit), 32'h0);
    check("spawn_swap_used", 32'(swap_used), 32'h0);

    // Gravity every 4 frames
    frame(); frame(); frame(); tick(); tick();
    check("grav3_no_req", 32'(chk_req), 32'h0);
    frame(); tick();
    check("grav4_req", 32'(chk_req), 32'h1);
    check("grav4_op", 32'(chk_op), 32'h3);
    answer(1'b1);
    check("grav4_commit", 32'(commit), 32'h1);
    tick();
    frame(); frame(); frame(); tick(); tick();
    check("grav7_no_req", 32'(chk_req), 32'h0);
    frame(); tick();
    check("grav8_req", 32'(chk_req), 32'h1);
    answer(1'b0);
    check("lock_state", 32'(state), 32'h4);
    check("lock_pulse", 32'(lock), 32'h1);
    check("lock_no_commit", 32'(commit), 32'h0);
    tick();
    check("clear_state", 32'(state), 32'h5);
    check("lock_pulse_end", 32'(lock), 32'h0);
    tick();
    check("clear_wait", 32'(state), 32'h5);
    clear_done = 1'b1; tick(); clear_done = 1'b0;
    check("clear_to_spawn", 32'(state), 32'h0);
    tick();
    check("respawn_op", 32'(chk_op), 32'h0);
    answer(1'b1); tick();
    check("respawn_idle", 32'(state), 32'h1);

    // Held LEFT repeats at press, +8, +16 frames; gravity keeps its period
    ok_left = 1000; clr_counts();
    keycode = 8'h04; run_frames(20);
    check("left_repeat_count", 32'(n_chk[1]), 32'd3);
    check("left_grav_count", 32'(n_chk[3]), 32'd5);
    check("left_commits", 32'(n_commit), 32'd8);
    keycode = 8'h00; run_frames(4);
    clr_counts();
    keycode = 8'h1A; run_frames(20);
    check("rot_once", 32'(n_chk[4]), 32'd1);
    check("rot_grav_count", 32'(n_chk[3]), 32'd5);
    keycode = 8'h00; run_frames(4);

    // SWAP once per piece
    clr_counts();
    keycode = 8'h06; drive(16, 1'b0);
    check("swap_chk", 32'(n_chk[5]), 32'd1);
    check("swap_respawn_chk", 32'(n_chk[0]), 32'd1);
    check("swap_commits", 32'(n_commit), 32'd2);
    check("swap_spawn_state", 32'(n_spawn), 32'd1);
    check("swap_used_set", 32'(swap_used), 32'h1);
    check("swap_idle", 32'(state), 32'h1);
    keycode = 8'h00; drive(2, 1'b0);
    clr_counts();
    keycode = 8'h06; drive(12, 1'b0);
    check("swap2_ignored", 32'(n_chk[5] + n_chk[0]), 32'd0);
    check("swap2_used", 32'(swap_used), 32'h1);
    keycode = 8'h00;
    clr_counts(); ok_left = 0;
    run_frames(4);
    check("swap_lock_count", 32'(n_lock), 32'd1);
    check("swap_lock_down", 32'(n_chk[3]), 32'd1);
    check("swap_lock_clear", 32'(state), 32'h5);
    check("swap_used_cleared", 32'(swap_used), 32'h0);
    clear_done = 1'b1; tick(); clear_done = 1'b0;
    ok_left = 1000; clr_counts(); drive(8, 1'b0);
    check("post_clear_spawn", 32'(n_chk[0]), 32'd1);
    check("post_clear_idle", 32'(state), 32'h1);

`ifdef HARD_DROP_EN
    clr_counts(); ok_left = 5;
    keycode = 8'h2C; drive(40, 1'b0);
    check("hard_down_checks", 32'(n_chk[3]), 32'd6);
    check("hard_commits", 32'(n_commit), 32'd5);
    check("hard_locks", 32'(n_lock), 32'd1);
    check("hard_clear", 32'(state), 32'h5);
`else
    clr_counts();
    keycode = 8'h2C; drive(12, 1'b0);
    check("code2c_ignored", 32'(n_chk[3]), 32'd0);
    check("code2c_idle", 32'(state), 32'h1);
`endif
    keycode = 8'h00;

    // Reset during a pending handshake
    Reset_n = 1'b0; tick(); Reset_n = 1'b1;
    tick();
    check("mid_req_high", 32'(chk_req), 32'h1);
    Reset_n = 1'b0; #1;
    check("mid_rst_req", 32'(chk_req), 32'h0);
    check("mid_rst_state", 32'(state), 32'h0);
    Reset_n = 1'b1;
    tick();
    check("over_spawn_req", 32'(chk_req), 32'h1);
    answer(1'b0);
    check("over_state", 32'(state), 32'h6);
    check("over_flag", 32'(game_over), 32'h1);
    clr_counts(); ok_left = 1000;
    keycode = 8'h04; run_frames(8);
    keycode = 8'h1A; drive(4, 1'b0);
    check("over_no_checks", 32'(n_chk[0] + n_chk[1] + n_chk[3] + n_chk[4]), 32'd0);
    check("over_no_commit", 32'(n_commit + n_lock), 32'd0);
    check("over_stays", 32'(state), 32'h6);
    check("over_sticky", 32'(game_over), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/piece_sched.md
Name: piece_sched

Overview:
- Sequencing controller for the active-piece write buffer and the collision checker.
- Generates the 3-bit game state that tells the write buffer when to spawn (000), and arbitrates between gravity ticks and keyboard actions (left, right, soft drop, rotate, swap).
- Issues one collision-check request at a time over a req/ack handshake, then commits, locks, clears lines or ends the game.

Parameters:
DROP_TICKS, 50, frame_ticks between gravity steps (>=2)
KEY_REPEAT, 8, frame_ticks a held left/right/down key waits before auto-repeat (>=1)

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse per video frame
keycode  in  8  current USB keycode, 0 = none
chk_ok  in  1  checker result, valid when chk_ack=1
chk_ack  in  1  checker done, one-cycle pulse
clear_done  in  1  line-clear engine finished, one-cycle pulse
state  out  3  000 SPAWN, 001 IDLE, 010 CHECK, 011 APPLY, 100 LOCK, 101 CLEAR, 110 OVER
chk_req  out  1  collision check request, level
chk_op  out  3  0 SPAWN, 1 LEFT, 2 RIGHT, 3 DOWN, 4 ROT, 5 SWAP
commit  out  1  one-cycle pulse: apply chk_op to buffer
lock  out  1  one-cycle pulse: merge piece into board
swap_used  out  1  hold already used for current piece
game_over  out  1  sticky end flag

Behaviour:
- Reset (async assert, sync release): state=SPAWN, chk_req=0, chk_op=0, commit=0, lock=0, swap_used=0, game_over=0, gravity counter=0, pending flags=0, previous-key register=0. Reset mid-operation abandons any handshake.
- Key events, from `keycode` vs the previous-cycle keycode:
  - Press = keycode changed to nonzero. 0x04 LEFT, 0x07 RIGHT, 0x16 DOWN, 0x1A ROT, 0x06 SWAP; other codes ignored.
  - A held 0x04, 0x07 or 0x16 re-fires every KEY_REPEAT frame_ticks after its press. ROT and SWAP never repeat.
  - Events are latched in a one-deep pending register; a newer event overwrites an unserviced one.
- Gravity:
  - Counter increments on frame_tick in every state except OVER.
  - On reaching DROP_TICKS-1, the next frame_tick resets it to 0 and sets grav_pend.
  - A committed DOWN of either source resets the counter to 0 and clears grav_pend.
- SPAWN: one cycle, then CHECK with chk_op=SPAWN.
- IDLE:
  - grav_pend has priority and is serviced as DOWN.
  - Otherwise a pending key event is serviced. SWAP is discarded if swap_used=1.
  - Servicing clears the pending flag and goes to CHECK. With nothing pending, stay in IDLE.
- CHECK:
  - chk_req=1 with chk_op stable until the cycle chk_ack=1, then chk_req drops the next cycle.
  - chk_ok=1 goes to APPLY.
  - chk_ok=0 depends on op: SPAWN goes to OVER; DOWN goes to LOCK; LEFT, RIGHT, ROT and SWAP go to IDLE.
  - chk_ack in any other state is ignored.
- APPLY:
  - commit=1 for one cycle.
  - SWAP sets swap_used and goes to SPAWN (the buffer reloads the held or new block).
  - SPAWN and all other ops go to IDLE.
- LOCK: lock=1 for one cycle, swap_used cleared, then CLEAR.
- CLEAR: wait for clear_done, then SPAWN. Key presses during CLEAR are latched.
- OVER: terminal until reset. game_over=1, all pulses 0, inputs ignored.
- Simultaneous frame_tick plus key press in one cycle: both are latched; gravity is serviced first.
- Outputs are registered; state changes one cycle after the decision input.

Optional Feature:
- Macro HARD_DROP_EN.
- Defined: press of 0x2C is latched as HARD (priority below gravity).
  - Servicing issues DOWN checks back to back: CHECK, APPLY, CHECK, ... with no IDLE in between, until chk_ok=0, then LOCK.
  - Other events latched meanwhile are held until the next IDLE.
  - grav_pend is cleared on entry to LOCK.
- Not defined: 0x2C is ignored like any unknown code.

Test Plan:
- Release reset, answer SPAWN check chk_ok=1 -> commit pulse, state 000 -> 010 -> 011 -> 001, swap_used=0.
- DROP_TICKS=4, no keys, chk_ok=1 -> DOWN check requested every 4 frame_ticks; then chk_ok=0 -> lock pulse, state 100 -> 101; clear_done -> 000.
- Hold keycode 0x04 for 20 frames with KEY_REPEAT=8 -> LEFT checks at press, frame 8 and frame 16 (3 total); 0x1A held -> exactly one ROT.
- Press 0x06 twice within one piece -> first SWAP commits and swap_used=1 with state to 000; second ignored; after lock swap_used=0.
- SPAWN check with chk_ok=0 -> state 110, game_over=1, later keycodes and frame_ticks produce no chk_req.
- Reset_n low while chk_req=1 -> chk_req=0 immediately, state=000; with HARD_DROP_EN, 0x2C on empty board and 5 ok answers then a fail -> 6 DOWN checks, 5 commits, 1 lock.
